// File: rtl/ifft16_seq.sv
// ---------------------------------------------------------------------------
// ifft16_seq
//   Sequential 16-point inverse FFT built around one shared radix-2 butterfly
//   that works in place on a 16-entry register file.
//
//   A frame of 16 frequency samples X[0..15] is loaded in natural order. Each
//   sample is stored at its bit-reversed address. The block then runs
//   4 stages x 8 butterflies, one butterfly per cycle. Every stage halves its
//   results, so the frame comes out scaled by 1/16. The time samples
//   x[0..15] are then streamed out in natural order.
//
//   Handshake (both streams): a beat transfers on a rising clock edge when
//   valid and ready are both high. The producer holds data stable while
//   valid is high and ready is low. in_ready is high only in LOAD.
//   out_valid is high only in UNLOAD. out_data and out_last hold while the
//   output is stalled.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   in_data    X[k] as {re[31:16], im[15:0]}, Q4.11 two's complement
//   in_valid   in_data valid
//   in_ready   block accepts in_data (LOAD)
//   out_data   x[n] as {re, im}, Q4.11
//   out_valid  out_data valid (UNLOAD)
//   out_ready  downstream accepts out_data
//   out_last   high with out_valid on x[15]
//   busy       high in COMPUTE and UNLOAD
// ---------------------------------------------------------------------------
module ifft16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy
);

    localparam int N_PTS = 16;
    localparam logic [3:0] LAST_IDX = 4'(N_PTS - 1);
    localparam logic [4:0] LAST_BFLY = 5'd31;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  k_cnt;    // input sample index
    logic [4:0]  c_cnt;    // butterfly index: [4:3] stage, [2:0] butterfly
    logic [3:0]  n_cnt;    // output sample index

    logic [31:0] mem [0:15];

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        bitrev4 = {v[0], v[1], v[2], v[3]};
    endfunction

    // W[t] = exp(+j*pi*t/8) in Q4.11. The value for t=4 is 2047 so that the
    // entry matches the forward transform's twiddle table.
    function automatic logic [31:0] twiddle(input logic [2:0] t);
        case (t)
            3'd0:    twiddle = {16'h0800, 16'h0000};  // ( 2048,    0)
            3'd1:    twiddle = {16'h0764, 16'h030F};  // ( 1892,  783)
            3'd2:    twiddle = {16'h05A8, 16'h05A8};  // ( 1448, 1448)
            3'd3:    twiddle = {16'h030F, 16'h0764};  // (  783, 1892)
            3'd4:    twiddle = {16'h0000, 16'h07FF};  // (    0, 2047)
            3'd5:    twiddle = {16'hFCF1, 16'h0764};  // ( -783, 1892)
            3'd6:    twiddle = {16'hFA58, 16'h05A8};  // (-1448, 1448)
            default: twiddle = {16'hF89C, 16'h030F};  // (-1892,  783)
        endcase
    endfunction

    // Q4.11 multiply done on magnitudes, so truncation goes toward zero. The
    // sign is applied afterwards.
    function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] ma;
        logic [15:0] mb;
        logic [31:0] prod;
        logic [15:0] mag;
        ma   = a[15] ? (~a + 16'd1) : a;
        mb   = b[15] ? (~b + 16'd1) : b;
        prod = {16'd0, ma} * {16'd0, mb};
        mag  = prod[26:11];
        qmul = (a[15] ^ b[15]) ? (~mag + 16'd1) : mag;
    endfunction

    // -----------------------------------------------------------------------
    // Butterfly addressing and datapath
    // -----------------------------------------------------------------------
    logic [1:0]  stage;
    logic [2:0]  bfly;
    logic [3:0]  idx0;
    logic [3:0]  idx1;
    logic [2:0]  tw_idx;

    assign stage = c_cnt[4:3];
    assign bfly  = c_cnt[2:0];

    // i0 = (b>>s)*2*half + (b & (half-1)) is bit b inserted as a 0 at
    // position s. i1 has a 1 at that position. The twiddle index is
    // (b & (half-1)) << (3-s).
    always_comb begin
        idx0   = 4'd0;
        idx1   = 4'd0;
        tw_idx = 3'd0;
        case (stage)
            2'd0: begin
                idx0   = {bfly, 1'b0};
                idx1   = {bfly, 1'b1};
                tw_idx = 3'd0;
            end
            2'd1: begin
                idx0   = {bfly[2:1], 1'b0, bfly[0]};
                idx1   = {bfly[2:1], 1'b1, bfly[0]};
                tw_idx = {bfly[0], 2'b00};
            end
            2'd2: begin
                idx0   = {bfly[2], 1'b0, bfly[1:0]};
                idx1   = {bfly[2], 1'b1, bfly[1:0]};
                tw_idx = {bfly[1:0], 1'b0};
            end
            default: begin
                idx0   = {1'b0, bfly};
                idx1   = {1'b1, bfly};
                tw_idx = bfly;
            end
        endcase
    end

    logic [31:0] a_val;
    logic [31:0] b_val;
    logic [31:0] w_val;
    logic [15:0] rr, ii, ri, ir;
    logic [15:0] p_re, p_im;
    logic [16:0] sum_re, sum_im, dif_re, dif_im;
    logic [31:0] new0, new1;

    assign a_val = mem[idx0];
    assign b_val = mem[idx1];
    assign w_val = twiddle(tw_idx);

    assign rr = qmul(w_val[31:16], b_val[31:16]);
    assign ii = qmul(w_val[15:0],  b_val[15:0]);
    assign ri = qmul(w_val[31:16], b_val[15:0]);
    assign ir = qmul(w_val[15:0],  b_val[31:16]);

    assign p_re = rr - ii;
    assign p_im = ri + ir;

    // 17-bit sums; dropping the LSB is the arithmetic >>>1 for the stage
    // halving.
    assign sum_re = {a_val[31], a_val[31:16]} + {p_re[15], p_re};
    assign sum_im = {a_val[15], a_val[15:0]}  + {p_im[15], p_im};
    assign dif_re = {a_val[31], a_val[31:16]} - {p_re[15], p_re};
    assign dif_im = {a_val[15], a_val[15:0]}  - {p_im[15], p_im};

    assign new0 = {sum_re[16:1], sum_im[16:1]};
    assign new1 = {dif_re[16:1], dif_im[16:1]};

    logic in_fire;
    logic out_fire;

    assign in_fire  = (state == ST_LOAD) && in_valid && in_ready;
    assign out_fire = (state == ST_UNLOAD) && out_valid && out_ready;

    // -----------------------------------------------------------------------
    // Register file. The contents after reset are don't-care, so it has no
    // reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[bitrev4(k_cnt)] <= in_data;
        end else if (state == ST_COMPUTE) begin
            mem[idx0] <= new0;
            mem[idx1] <= new1;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            k_cnt     <= 4'd0;
            c_cnt     <= 5'd0;
            n_cnt     <= 4'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            out_data  <= 32'd0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        if (k_cnt == LAST_IDX) begin
                            k_cnt    <= 4'd0;
                            c_cnt    <= 5'd0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= ST_COMPUTE;
                        end else begin
                            k_cnt <= k_cnt + 4'd1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    c_cnt <= c_cnt + 5'd1;
                    if (c_cnt == LAST_BFLY) begin
                        // The final butterfly touches mem[7]/mem[15], so
                        // mem[0] is already final here.
                        out_data  <= mem[0];
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        n_cnt     <= 4'd0;
                        state     <= ST_UNLOAD;
                    end
                end
                ST_UNLOAD: begin
                    if (out_fire) begin
                        if (n_cnt == LAST_IDX) begin
                            n_cnt     <= 4'd0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= 32'd0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= ST_LOAD;
                        end else begin
                            n_cnt    <= n_cnt + 4'd1;
                            out_data <= mem[n_cnt + 4'd1];
                            out_last <= (n_cnt == LAST_IDX - 4'd1);
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifft16_seq.sv
// ---------------------------------------------------------------------------
// tb_ifft16_seq
//   Directed bench for ifft16_seq. Each frame is loaded and the 16 outputs
//   are compared against hand-computed time samples, allowing the per-case
//   tolerance. The bench also covers reset values, handshake timing, stalls
//   on both streams, and a reset during COMPUTE.
// ---------------------------------------------------------------------------
module tb_ifft16_seq;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  int n_cmp;
  int n_err;

  logic [31:0] frame_in [16];
  int          exp_re   [16];
  int          exp_im   [16];

  // 128 * exp(+j*2*pi*n/16), rounded
  int tone_re [16] = '{128, 118, 91, 49, 0, -49, -91, -118, -128, -118, -91, -49, 0, 49, 91, 118};
  int tone_im [16] = '{0, 49, 91, 118, 128, 118, 91, 49, 0, -49, -91, -118, -128, -118, -91, -49};
  // 0.919 * 2048 * sin(pi*n/4) = 1882 * sin(pi*n/4)
  int sine_re [16] = '{0, 1331, 1882, 1331, 0, -1331, -1882, -1331, 0, 1331, 1882, 1331, 0, -1331, -1882, -1331};

  ifft16_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  // -------------------------------------------------------------------------
  // Clock
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input int obs, input int exp, input int tol);
    int diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    n_cmp++;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic logic [31:0] pk(input int re, input int im);
    pk = {re[15:0], im[15:0]};
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < 16; i++) begin
      frame_in[i] = 32'd0;
      exp_re[i]   = 0;
      exp_im[i]   = 0;
    end
  endtask

  // -------------------------------------------------------------------------
  // Drivers
  // -------------------------------------------------------------------------
  // Inputs change on the falling edge. A beat counts as accepted when
  // in_valid and in_ready are both high at that point, because it then
  // transfers on the next rising edge.
  task automatic send_frame(input bit gaps);
    int  k;
    int  guard;
    bit  v;
    k = 0;
    guard = 0;
    while (k < 16 && guard < 400) begin
      @(negedge clk);
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = frame_in[k];
      if (v && in_ready) k++;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'd0;
    check("load_beats", k, 16, 0);
  endtask

  task automatic recv_frame(input bit stall, input int tol, input string name);
    int n;
    int cyc;
    int first;
    bit r;
    n = 0;
    cyc = 0;
    first = -1;
    while (n < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        r        = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));   // must be ignored while busy
        in_data  = $urandom;
      end else begin
        r = 1'b1;
      end
      out_ready = r;
      if (cyc == 1) begin
        check({name, "_busy"}, int'(busy), 1, 0);
        check({name, "_in_ready_busy"}, int'(in_ready), 0, 0);
      end
      if (out_valid) begin
        if (first < 0) first = cyc;
        check($sformatf("%s_re%0d", name, n), int'($signed(out_data[31:16])), exp_re[n], tol);
        check($sformatf("%s_im%0d", name, n), int'($signed(out_data[15:0])), exp_im[n], tol);
        check($sformatf("%s_last%0d", name, n), int'(out_last), (n == 15) ? 1 : 0, 0);
        if (r) n++;
      end
    end
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    check({name, "_beats"}, n, 16, 0);
    if (!stall) check({name, "_latency"}, first, 32, 0);
    @(negedge clk);
    check({name, "_idle_in_ready"}, int'(in_ready), 1, 0);
    check({name, "_idle_valid"}, int'(out_valid), 0, 0);
    check({name, "_idle_busy"}, int'(busy), 0, 0);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1, 0);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_out_last", int'(out_last), 0, 0);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_out_data", int'(out_data), 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Impulse: every output is exactly (128, 0).
    clear_frame();
    frame_in[0] = pk(2048, 0);
    for (int i = 0; i < 16; i++) exp_re[i] = 128;
    send_frame(1'b0);
    recv_frame(1'b0, 0, "imp");

    // Constant: only x[0] is nonzero.
    clear_frame();
    for (int i = 0; i < 16; i++) frame_in[i] = pk(2048, 0);
    exp_re[0] = 2048;
    send_frame(1'b0);
    recv_frame(1'b0, 1, "dc");

    // Tone in bin 1
    clear_frame();
    frame_in[1] = pk(2048, 0);
    for (int i = 0; i < 16; i++) begin
      exp_re[i] = tone_re[i];
      exp_im[i] = tone_im[i];
    end
    send_frame(1'b0);
    recv_frame(1'b0, 2, "tone");

    // Round trip: X[2] = -j*8A and X[14] = +j*8A for a sine of amplitude A = 0.919.
    clear_frame();
    frame_in[2]  = pk(0, -15057);
    frame_in[14] = pk(0, 15057);
    for (int i = 0; i < 16; i++) exp_re[i] = sine_re[i];
    send_frame(1'b0);
    recv_frame(1'b0, 4, "sine");

    // Tone again, with gaps on the input and stalls on the output
    clear_frame();
    frame_in[1] = pk(2048, 0);
    for (int i = 0; i < 16; i++) begin
      exp_re[i] = tone_re[i];
      exp_im[i] = tone_im[i];
    end
    send_frame(1'b1);
    recv_frame(1'b1, 2, "flow");

    // Reset in cycle 10 of COMPUTE, then an impulse frame
    clear_frame();
    for (int i = 0; i < 16; i++) frame_in[i] = pk(1000 + i, -i);
    send_frame(1'b0);
    repeat (9) @(negedge clk);
    check("mid_busy", int'(busy), 1, 0);
    rst = 1'b1;
    #1;
    check("abort_in_ready", int'(in_ready), 1, 0);
    check("abort_out_valid", int'(out_valid), 0, 0);
    check("abort_busy", int'(busy), 0, 0);
    check("abort_out_data", int'(out_data), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_stay_idle", int'(out_valid), 0, 0);
    clear_frame();
    frame_in[0] = pk(2048, 0);
    for (int i = 0; i < 16; i++) exp_re[i] = 128;
    send_frame(1'b0);
    recv_frame(1'b0, 0, "post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
